// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler:
// opcodes, scheduler states and the per-opcode ALU hold time.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_MULT = 3'd2;
    localparam logic [2:0] ALU_NAND = 3'd3;
    localparam logic [2:0] ALU_DIV  = 3'd4;
    localparam logic [2:0] ALU_MOD  = 3'd5;
    localparam logic [2:0] ALU_ROTL = 3'd6;
    localparam logic [2:0] ALU_NOP  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    function automatic logic [7:0] op_lat(
        input logic [2:0] op,
        input int         mult_lat,
        input int         div_lat
    );
        logic [7:0] l;
        l = 8'd1;
        unique case (1'b1)
            (op == ALU_MULT): l = 8'(mult_lat);
            (op == ALU_DIV),
            (op == ALU_MOD):  l = 8'(div_lat);
            default:          l = 8'd1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or
// after ptr (wrapping) wins; one-hot grant plus index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : arb
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among requesters.
// Optional: ALU_SCHED_DIV0_TRAP_EN traps DIV/MOD by zero.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_BITS = 16,
    parameter int OP_BITS  = 3,
    parameter int MULT_LAT = 2,
    parameter int DIV_LAT  = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*OP_BITS-1:0]  req_op,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_a,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_b,
    output logic [OP_BITS-1:0]          alu_operator,
    output logic [NUM_BITS-1:0]         alu_op1,
    output logic [NUM_BITS-1:0]         alu_op2,
    input  logic [NUM_BITS-1:0]         alu_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IW-1:0]               rsp_id,
    output logic [NUM_BITS-1:0]         rsp_data,
    output logic                        rsp_err
);

    state_t state, state_n;

    logic [IW-1:0]       ptr;
    logic [IW-1:0]       id_q;
    logic [IW-1:0]       win_idx;
    logic [NUM_REQ-1:0]  win_gnt;
    logic                win_any;

    logic [OP_BITS-1:0]  op_q;
    logic [NUM_BITS-1:0] a_q;
    logic [NUM_BITS-1:0] b_q;
    logic [7:0]          cnt;
    logic                trap_q;
    logic [NUM_BITS-1:0] data_q;
    logic                err_q;

    logic [OP_BITS-1:0]  sel_op;
    logic [NUM_BITS-1:0] sel_a;
    logic [NUM_BITS-1:0] sel_b;
    logic                sel_trap;
    logic [7:0]          sel_lat;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign sel_op = req_op[int'(win_idx)*OP_BITS +: OP_BITS];
    assign sel_a  = req_a[int'(win_idx)*NUM_BITS +: NUM_BITS];
    assign sel_b  = req_b[int'(win_idx)*NUM_BITS +: NUM_BITS];

`ifdef ALU_SCHED_DIV0_TRAP_EN
    assign sel_trap = ((sel_op == ALU_DIV) || (sel_op == ALU_MOD))
                      && (sel_b == '0);
`else
    assign sel_trap = 1'b0;
`endif

    assign sel_lat = sel_trap ? 8'd1
                   : op_lat(sel_op, MULT_LAT, DIV_LAT);

    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign rsp_err  = err_q;

    always_comb begin
        state_n      = state;
        req_ready    = '0;
        alu_operator = OP_BITS'(ALU_NOP);
        alu_op1      = '0;
        alu_op2      = '0;
        rsp_valid    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (win_any) begin
                    req_ready = win_gnt;
                    state_n   = S_EXEC;
                end
            end
            S_EXEC: begin
                // a trapped divide keeps the ALU idle
                if (!trap_q) begin
                    alu_operator = op_q;
                    alu_op1      = a_q;
                    alu_op2      = b_q;
                end
                if (cnt == 8'd0) state_n = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            ptr    <= '0;
            id_q   <= '0;
            op_q   <= OP_BITS'(ALU_NOP);
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            trap_q <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE: begin
                    if (win_any) begin
                        id_q   <= win_idx;
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        trap_q <= sel_trap;
                        cnt    <= sel_lat - 8'd1;
                    end
                end
                S_EXEC: begin
                    if (cnt == 8'd0) begin
                        data_q <= trap_q ? '1 : alu_result;
                        err_q  <= trap_q;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        ptr <= (id_q == IW'(NUM_REQ - 1))
                               ? '0 : id_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized self-checking bench for alu_sched with a
// transaction-level model; honours ALU_SCHED_DIV0_TRAP_EN.
module tb_alu_sched;

    localparam int NR = 2;
    localparam int W  = 16;
    localparam int ML = 2;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*3-1:0] req_op;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [2:0]    alu_operator;
    logic [W-1:0]  alu_op1;
    logic [W-1:0]  alu_op2;
    logic [W-1:0]  alu_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [0:0]    rsp_id;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;

    logic [2:0]   op_arr [NR];
    logic [W-1:0] a_arr  [NR];
    logic [W-1:0] b_arr  [NR];

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_op[g*3 +: 3] = op_arr[g];
        assign req_a[g*W +: W]  = a_arr[g];
        assign req_b[g*W +: W]  = b_arr[g];
    end

    always #5 clk = ~clk;

    alu_sched #(
        .NUM_REQ  (NR),
        .NUM_BITS (W),
        .OP_BITS  (3),
        .MULT_LAT (ML),
        .DIV_LAT  (DL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_operator (alu_operator),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    function automatic logic [W-1:0] alu_fn(
        input logic [2:0] op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [2*W-1:0] t;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return ~(a & b);
            3'd4: return (b == 0) ? '1 : a / b;
            3'd5: return (b == 0) ? a : a % b;
            3'd6: begin
                t = {a, a} << b[3:0];
                return t[2*W-1:W];
            end
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_operator, alu_op1, alu_op2);

    function automatic bit is_trap(input logic [2:0] op, input logic [W-1:0] b);
`ifdef ALU_SCHED_DIV0_TRAP_EN
        return (op == 3'd4 || op == 3'd5) && b == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
        if (is_trap(op, b)) return 1;
        if (op == 3'd2) return ML;
        if (op == 3'd4 || op == 3'd5) return DL;
        return 1;
    endfunction

    function automatic int model_winner(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++) begin
            if (m[(mptr + i) % NR]) return (mptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_data", 32'(rsp_data), 0);
        check("rst_err", 32'(rsp_err), 0);
        check("rst_aluop", 32'(alu_operator), 7);
        check("rst_op12", {alu_op1, alu_op2}, 0);
        rst = 1'b1;
        mptr = 0;
    endtask

    // Starts between the accept-cycle sample and the next negedge.
    task automatic wait_rsp(input int w, input int hold);
        logic [2:0]   op;
        logic [W-1:0] a, b, ed;
        int lat, k;
        bit tr;
        op  = op_arr[w];
        a   = a_arr[w];
        b   = b_arr[w];
        tr  = is_trap(op, b);
        lat = exp_lat(op, b);
        ed  = tr ? '1 : alu_fn(op, a, b);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk); #1;
            check("exec_valid", 32'(rsp_valid), 0);
            check("exec_ready", 32'(req_ready), 0);
            check("exec_aluop", 32'(alu_operator), tr ? 7 : 32'(op));
            check("exec_op1", 32'(alu_op1), tr ? 0 : 32'(a));
            check("exec_op2", 32'(alu_op2), tr ? 0 : 32'(b));
        end
        @(negedge clk); #1;
        check("rsp_lat", 32'(rsp_valid), 1);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            req_valid = '0;
            return;
        end
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_id", 32'(rsp_id), w);
        check("rsp_err", 32'(rsp_err), 32'(tr));
        check("resp_aluop", 32'(alu_operator), 7);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_data", 32'(rsp_data), 32'(ed));
            check("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        mptr = (w + 1) % NR;
    endtask

    task automatic txn(input logic [NR-1:0] m, input int hold,
                       input bit keep);
        int w;
        @(negedge clk);
        req_valid = m;
        #1;
        w = model_winner(m);
        check("grant", 32'(req_ready), 32'(1) << w);
        @(posedge clk); #1;
        if (keep) req_valid[w] = 1'b0;
        else req_valid = '0;
        wait_rsp(w, hold);
    endtask

    task automatic set_req(input int r, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        op_arr[r] = op;
        a_arr[r]  = a;
        b_arr[r]  = b;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) set_req(i, 3'd0, '0, '0);
        do_reset();

        set_req(0, 3'd0, 16'h0003, 16'h0004);
        txn(2'b01, 0, 1'b1);

        do_reset();
        set_req(0, 3'd1, 16'd50, 16'd8);
        set_req(1, 3'd3, 16'hF0F0, 16'h0FF0);
        for (int r = 0; r < 3; r++) txn(2'b11, 0, 1'b1);

        set_req(0, 3'd4, 16'd100, 16'd7);
        txn(2'b01, 3, 1'b1);
        set_req(1, 3'd4, 16'd55, 16'd0);
        txn(2'b10, 1, 1'b1);
        set_req(0, 3'd5, 16'd9, 16'd0);
        txn(2'b01, 0, 1'b1);

        // pointer now 1: abandon a MULT on req1 by reset
        set_req(1, 3'd2, 16'd300, 16'd5);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check("mult_grant", 32'(req_ready), 2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        check("mult_exec", 32'(alu_operator), 2);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mptr = 0;
        @(negedge clk); #1;
        check("rst_exec_valid", 32'(rsp_valid), 0);
        check("rst_exec_aluop", 32'(alu_operator), 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("no_stale", 32'(rsp_valid), 0);
        end
        set_req(0, 3'd6, 16'h8001, 16'd1);
        txn(2'b11, 0, 1'b0);

        // req1 withdraws while req0 is served
        do_reset();
        set_req(0, 3'd2, 16'd123, 16'd45);
        txn(2'b11, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("withdraw_valid", 32'(rsp_valid), 0);
            check("withdraw_ready", 32'(req_ready), 0);
        end

        for (int t = 0; t < 60; t++) begin
            logic [NR-1:0] m;
            for (int i = 0; i < NR; i++) begin
                logic [W-1:0] rb;
                rb = W'($urandom);
                if ($urandom_range(0, 4) == 0) rb = '0;
                set_req(i, 3'($urandom_range(0, 7)), W'($urandom), rb);
            end
            m = NR'($urandom_range(1, (1 << NR) - 1));
            txn(m, $urandom_range(0, 2), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Request scheduler sharing one combinational 16-bit ALU (ADD/SUB/MULT/NAND/DIV/MOD/ROTL/NOP, 3-bit operator) among several requesters. It arbitrates round-robin, latches the winner's opcode and operands, and holds them on the ALU for an opcode-dependent number of cycles so the slow MULT/DIV/MOD paths can settle. It then returns a tagged, registered result over a valid/ready handshake. It sits between the instruction-issue logic and the ALU.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- NUM_BITS, 16, datapath width
- OP_BITS, 3, operator width
- MULT_LAT, 2, ALU-hold cycles for MULT
- DIV_LAT, 4, ALU-hold cycles for DIV and MOD
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  grant/accept, one-hot or zero
- req_op  in  NUM_REQ*OP_BITS  flattened opcodes, requester 0 in LSBs
- req_a, req_b  in  NUM_REQ*NUM_BITS  flattened operands
- alu_operator  out  OP_BITS  to ALU
- alu_op1, alu_op2  out  NUM_BITS  to ALU
- alu_result  in  NUM_BITS  from ALU (combinational)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts
- rsp_id  out  clog2(NUM_REQ)  index of requester served
- rsp_data  out  NUM_BITS  result
- rsp_err  out  1  divide-by-zero flag (see Configuration)

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any req_valid, rotating-priority arbiter picks winner starting at pointer; req_ready[winner]=1 combinationally that cycle; opcode/operands/id latched at the edge; cnt loaded with lat-1; go EXEC. req_ready is 0 in every other state.
- lat: MULT→MULT_LAT, DIV/MOD→DIV_LAT, all others→1.
- EXEC: alu_operator/op1/op2 driven from latched registers; cnt decrements; when cnt==0, capture alu_result into rsp_data at the edge, go RESP.
- RESP: rsp_valid=1, rsp_data/rsp_id/rsp_err stable until rsp_valid&&rsp_ready; on handshake go IDLE, pointer = winner+1 mod NUM_REQ.
- Outside EXEC, alu_operator=NOP (3'h7), alu_op1/op2=0.
- Requester must hold req_valid and operands until its req_ready; dropping req_valid before grant withdraws the request.
- rsp_ready ignored outside RESP.

## Timing
- Reset (rst==0 at edge): state IDLE, pointer 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, alu_operator 3'h7, alu_op1/op2 0.
- Reset mid-EXEC or mid-RESP abandons the transaction; no response is produced.
- Accept cycle c0; rsp_valid first high in cycle c0+lat+1 (ADD: c0+2; DIV with DIV_LAT=4: c0+5).
- One IDLE bubble after each response handshake; back-to-back ADD throughput is one op per 3 cycles when rsp_ready=1.
- Simultaneous requests: lowest index at or after pointer wins; losers keep req_ready=0 and wait.
- Pointer wrap: winner NUM_REQ-1 → pointer 0.

## Configuration
- ALU_SCHED_DIV0_TRAP_EN defined: DIV/MOD with latched op2==0 skips ALU hold (lat=1, ALU driven NOP), rsp_data=all-ones, rsp_err=1.
- Undefined: divide-by-zero is issued to ALU normally; rsp_err tied 0.

## Structure
- Shared package alu_pkg: opcode constants ALU_ADD=0, ALU_SUB=1, ALU_MULT=2, ALU_NAND=3, ALU_DIV=4, ALU_MOD=5, ALU_ROTL=6, ALU_NOP=7; state enum; latency-lookup function.
- One sub-module: rr_arbiter (req vector, pointer → one-hot grant, encoded index).

## Test plan
- Single ADD from req0, a=16'h0003, b=16'h0004 -> req_ready[0] in c0, rsp_valid in c2, rsp_data=16'h0007, rsp_id=0.
- req0 and req1 valid together, pointer 0, three rounds -> grants 0,1,0; rsp_id alternates.
- DIV a=100 b=7 with DIV_LAT=4, rsp_ready low 3 cycles -> rsp_valid at c0+5, rsp_data=14 held stable until handshake.
- DIV b=0 -> with ALU_SCHED_DIV0_TRAP_EN: rsp_data=16'hFFFF, rsp_err=1, rsp_valid at c0+2; without: rsp_err=0.
- rst low during EXEC of MULT -> next cycle IDLE, rsp_valid 0, alu_operator 3'h7, pointer 0; no stale response after release.
- req1 withdraws req_valid before grant while req0 served -> req1 never granted, no rsp_id=1.
